// File: rtl/mem_access_pkg.sv
// Shared types and constants for the data-memory access unit.
// Big-endian lane numbering: byte offset k lives in bits [31-8k -: 8].
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        CAPTURE,
        WRITE,
        RESP,
        ERR
    } state_t;

    localparam int MAX_LATENCY = 4;
    localparam int CNT_W       = $clog2(MAX_LATENCY);

    // A request is rejected when its size is reserved or its address is not
    // naturally aligned for that size.
    function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_WORD: bad = (offset != 2'b00);
            SZ_HALF: bad = offset[0];
            SZ_BYTE: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts/extends sub-word loads and merges
// sub-word store data into a previously read memory word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase
        half_sel = offset[1] ? word[15:0] : word[31:16];
    end

    always_comb begin
        load_data = word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: load_data = word;
        endcase
    end

    // Only the addressed lane is replaced; every other bit comes from the read word.
    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd0:    store_word[31:24] = wdata[7:0];
                    2'd1:    store_word[23:16] = wdata[7:0];
                    2'd2:    store_word[15:8]  = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1])
                    store_word[15:0] = wdata[15:0];
                else
                    store_word[31:16] = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Responder side of the CPU data-memory interface: one request at a time,
// word accesses direct, sub-word stores via read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_LATENCY = 1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   lat_cnt;
    logic               wr_q;
    size_t              size_q;
    logic               sign_q;
    logic [1:0]         offset_q;
    logic [31:0]        wdata_q;
    logic [31:0]        data_q;
    logic               accept;
    logic               bad_req;
    size_t              req_size_e;
    logic [31:0]        load_data;
    logic [31:0]        store_word;

    assign req_size_e = size_t'(req_size);
    assign accept     = req_valid && req_ready;
    assign bad_req    = is_misaligned(req_size_e, req_addr[1:0]);

    mem_lane_align u_align (
        .word       (mem_rdata),
        .offset     (offset_q),
        .size       (size_q),
        .sign_ext   (sign_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Strobes decode straight from the state so an async reset drops mem_wr at once.
    always_comb begin
        state_d    = state_q;
        req_ready  = (state_q == IDLE) && reset;
        mem_wr     = (state_q == WRITE);
        resp_valid = (state_q == RESP) || (state_q == ERR);
        resp_error = (state_q == ERR);
        resp_rdata = ((state_q == RESP) && !wr_q) ? data_q : 32'h0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_req)
                        state_d = ERR;
                    else if (req_write && (req_size_e == SZ_WORD))
                        state_d = WRITE;
                    else
                        state_d = RD_WAIT;
                end
            end
            RD_WAIT: if (lat_cnt == '0) state_d = CAPTURE;
            CAPTURE: state_d = wr_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_cnt   <= '0;
            wr_q      <= 1'b0;
            size_q    <= SZ_WORD;
            sign_q    <= 1'b0;
            offset_q  <= 2'b00;
            wdata_q   <= 32'h0;
            data_q    <= 32'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_q     <= req_write;
                        size_q   <= req_size_e;
                        sign_q   <= req_signed;
                        offset_q <= req_addr[1:0];
                        wdata_q  <= req_wdata;
                        lat_cnt  <= CNT_W'(MEM_LATENCY - 1);
                        if (!bad_req) begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            if (req_write && (req_size_e == SZ_WORD))
                                mem_wdata <= req_wdata;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt != '0)
                        lat_cnt <= lat_cnt - CNT_W'(1);
                end
                CAPTURE: begin
                    data_q <= load_data;
                    if (wr_q)
                        mem_wdata <= store_word;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Responder end of the CPU's data-memory interface; sits between the multicycle control/datapath and the word-wide Memoria.
- Accepts one load/store request at a time through a valid/ready handshake.
- Performs aligned word accesses directly. Sub-word stores use read-modify-write. Loaded bytes and halfwords are extracted and extended.
- Returns exactly one response pulse per accepted request; misaligned requests are flagged without touching memory.

Parameters:
- MEM_LATENCY, 1, cycles from mem_addr stable to mem_rdata valid (legal range 1..4).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 reserved
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  misaligned or reserved size, qualified by resp_valid
- mem_addr  out  32  word-aligned address to Memoria (bits [1:0] always 0)
- mem_wr  out  1  Memoria write strobe
- mem_wdata  out  32  Memoria write data
- mem_rdata  in  32  Memoria read data

Behaviour:
- Reset (reset low, async): state IDLE; resp_valid, resp_error, mem_wr = 0; resp_rdata, mem_addr, mem_wdata = 0. req_ready = 1 once reset is released.
- Accept: a request is accepted on the rising edge where req_valid && req_ready; call that cycle T. All req_* fields are latched. req_valid is ignored outside IDLE.
- Byte ordering is big-endian. Byte offset k = addr[1:0] occupies bits [31-8k -: 8]. Half at offset 0 is [31:16]; half at offset 2 is [15:0].
- Error check at accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0.
  - Next state is ERR.
  - resp_valid=1 and resp_error=1 in cycle T+1.
  - No mem_wr; mem_addr is not updated.
- States: IDLE, RD_WAIT, CAPTURE, WRITE, RESP, ERR.
- Word store:
  - IDLE -> WRITE.
  - Cycle T+1: mem_addr = {addr[31:2],2'b00}, mem_wdata = req_wdata, mem_wr = 1 for exactly one cycle.
  - WRITE -> RESP; resp_valid in T+2.
- Load:
  - IDLE -> RD_WAIT; mem_addr is registered at T+1 and held.
  - RD_WAIT lasts MEM_LATENCY cycles, via a counter from MEM_LATENCY-1 down to 0.
  - CAPTURE (cycle T+1+MEM_LATENCY) samples mem_rdata and extracts/extends the data into resp_rdata.
  - RESP: resp_valid=1 in cycle T+2+MEM_LATENCY; word loads ignore req_signed.
- Half/byte store (read-modify-write):
  - Same RD_WAIT and CAPTURE as a load.
  - CAPTURE merges the addressed lane of req_wdata into the read word, giving mem_wdata.
  - WRITE: mem_wr = 1 in cycle T+2+MEM_LATENCY, for one cycle only.
  - RESP in T+3+MEM_LATENCY; all other lanes are preserved bit-exact.
- RESP and ERR return to IDLE. req_ready rises the cycle after resp_valid, so back-to-back requests are spaced by one idle cycle.
- resp_valid has no backpressure and is high exactly one cycle per accepted request. resp_rdata and resp_error are valid only while resp_valid is high and cleared otherwise.
- Reset low mid-operation: the operation is aborted and mem_wr drops immediately (async). No response is issued for the aborted request, and memory is never partially written.
- Address wrap: no increment is performed; any 32-bit address is accepted.

Decomposition:
- Package mem_access_pkg holds:
  - enum size_t {SZ_WORD, SZ_HALF, SZ_BYTE, SZ_RSVD};
  - enum state_t holding the six states;
  - constant MAX_LATENCY = 4.
- Sub-module mem_lane_align (purely combinational), instantiated once. Inputs: word, offset, size, signed, wdata. Outputs: the extracted/extended load value and the merged store word.

Test Plan (MEM_LATENCY=1, memory word 0x10 = 0x8899AABB, request accepted at T):
- Load byte, signed, addr 0x11 -> resp_rdata 0xFFFFFF99 at T+3. Repeating with req_signed=0 -> 0x00000099; mem_addr 0x10 throughout.
- Load half, signed, addr 0x12 -> 0xFFFFAABB. Load word, addr 0x10 -> 0x8899AABB with resp_error=0.
- Store byte, addr 0x12, wdata 0x00000055 -> single mem_wr cycle at T+3 with mem_wdata 0x889955BB; resp_valid at T+4; a following word load returns 0x889955BB.
- Store word, addr 0x20, wdata 0x12345678 -> mem_wr only at T+1 with mem_addr 0x20; resp_valid at T+2; req_ready low during T+1..T+2.
- Load word, addr 0x13, and separately req_size=11 -> resp_valid=1 and resp_error=1 at T+1; resp_rdata 0; mem_wr never asserted; mem_addr unchanged.
- Store byte, addr 0x11, with reset pulsed low during RD_WAIT -> mem_wr stays 0 and no resp_valid. After release req_ready=1, and memory word 0x10 is still 0x8899AABB.
